// File: rtl/c6288_tb_pkg.sv
// ---------------------------------------------------------------------------
// c6288_tb_pkg
//   Shared types and constants for the c6288 multiplier response compactor.
//   misr_state_t     : compactor FSM states
//   C6288_OUT_W      : width of the multiplier response vector
//   C6288_IN_W       : width of the multiplier operand vector
//   MISR_POLY_DEFAULT: default Galois feedback taps
// ---------------------------------------------------------------------------
package c6288_tb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } misr_state_t;

    localparam int          C6288_OUT_W       = 32;
    localparam int          C6288_IN_W        = 32;
    localparam logic [31:0] MISR_POLY_DEFAULT = 32'h8020_0003;

endpackage

// File: rtl/misr_core.sv
// ---------------------------------------------------------------------------
// misr_core
//   Galois MISR state register and step logic.
//   Parameters: W (register width), POLY (feedback taps).
//   Ports:
//     i_clk       clock, updates on posedge
//     i_rst_n     synchronous active-low reset, loads i_seed
//     i_load      load i_seed (has priority over i_en)
//     i_en        absorb i_din with one MISR step
//     i_seed      value loaded on reset/load
//     i_din       response vector to fold in
//     o_sig       current signature
//     o_sig_next  step result for the current inputs (MISR_GOLDEN_CHECK_EN only)
//   Build option: MISR_GOLDEN_CHECK_EN adds the o_sig_next port.
// ---------------------------------------------------------------------------
module misr_core #(
    parameter int           W    = 32,
    parameter logic [W-1:0] POLY = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_seed,
    input  logic [W-1:0] i_din,
`ifdef MISR_GOLDEN_CHECK_EN
    output logic [W-1:0] o_sig_next,
`endif
    output logic [W-1:0] o_sig
);

    logic [W-1:0] r_sig;
    logic [W-1:0] w_step;

    // Shift left; the bit falling off the MSB selects the feedback taps.
    assign w_step = {r_sig[W-2:0], 1'b0} ^ (r_sig[W-1] ? POLY : '0) ^ i_din;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sig <= i_seed;
        end else if (i_load) begin
            r_sig <= i_seed;
        end else if (i_en) begin
            r_sig <= w_step;
        end
    end

    assign o_sig = r_sig;
`ifdef MISR_GOLDEN_CHECK_EN
    assign o_sig_next = w_step;
`endif

endmodule

// File: rtl/c6288_response_misr.sv
// ---------------------------------------------------------------------------
// c6288_response_misr
//   Compacts c6288 multiplier responses into a Galois MISR signature and
//   flags completion after VEC_LENGTH accepted vectors.
//   Ports:
//     i_clk         clock, all state updates on posedge
//     i_rst_n       synchronous active-low reset
//     i_start       pulse: load SEED, clear count, enter CAPTURE
//     i_resp_valid  i_resp holds a valid response this cycle
//     i_resp        response vector {N545 ... N6288}, N545 at MSB
//     o_busy        high while capturing
//     o_done        high once VEC_LENGTH vectors are absorbed, until start/reset
//     o_count       vectors absorbed in the current run
//     o_signature   current MISR state
//     o_pass/o_fail final signature compare (MISR_GOLDEN_CHECK_EN only)
//   Build option: define MISR_GOLDEN_CHECK_EN for the GOLDEN_SIG comparator.
//
//   state   | meaning
//   --------+----------------------------------------------
//   IDLE    | waiting for start, responses ignored
//   CAPTURE | absorbing valid responses into the signature
//   DONE    | run complete, signature and count frozen
// ---------------------------------------------------------------------------
module c6288_response_misr
    import c6288_tb_pkg::*;
#(
    parameter int                   OUT_WIDTH  = C6288_OUT_W,
    parameter int                   VEC_LENGTH = 7,
    parameter logic [OUT_WIDTH-1:0] SEED       = '0,
    parameter logic [OUT_WIDTH-1:0] POLY       = MISR_POLY_DEFAULT,
    parameter logic [OUT_WIDTH-1:0] GOLDEN_SIG = '0,
    localparam int                  CW         = $clog2(VEC_LENGTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_resp_valid,
    input  logic [OUT_WIDTH-1:0] i_resp,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CW-1:0]        o_count,
`ifdef MISR_GOLDEN_CHECK_EN
    output logic                 o_pass,
    output logic                 o_fail,
`endif
    output logic [OUT_WIDTH-1:0] o_signature
);

    misr_state_t          r_state;
    misr_state_t          w_state_next;
    logic [CW-1:0]        r_count;
    logic                 w_load;
    logic                 w_en;
    logic                 w_last;
    logic [OUT_WIDTH-1:0] w_sig;
`ifdef MISR_GOLDEN_CHECK_EN
    logic [OUT_WIDTH-1:0] w_sig_next;
    logic                 r_pass;
    logic                 r_fail;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) w_state_next = CAPTURE;
            end
            CAPTURE: begin
                if (i_start)     w_state_next = CAPTURE;
                else if (w_last) w_state_next = DONE;
            end
            DONE: begin
                if (i_start) w_state_next = CAPTURE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Start restarts from any state and always beats a same-cycle vector.
    always_comb begin
        o_busy = (r_state == CAPTURE);
        o_done = (r_state == DONE);
        w_load = i_start;
        w_en   = (r_state == CAPTURE) && i_resp_valid && !i_start;
        w_last = w_en && (r_count == CW'(VEC_LENGTH - 1));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (w_load) begin
            r_count <= '0;
        end else if (w_en) begin
            r_count <= r_count + CW'(1);
        end
    end

    misr_core #(
        .W    (OUT_WIDTH),
        .POLY (POLY)
    ) u_misr_core (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_en       (w_en),
        .i_seed     (SEED),
        .i_din      (i_resp),
`ifdef MISR_GOLDEN_CHECK_EN
        .o_sig_next (w_sig_next),
`endif
        .o_sig      (w_sig)
    );

`ifdef MISR_GOLDEN_CHECK_EN
    // Verdict taken from the step result so it is valid on the DONE-entry edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (w_load) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (w_last) begin
            r_pass <= (w_sig_next == GOLDEN_SIG);
            r_fail <= (w_sig_next != GOLDEN_SIG);
        end
    end

    assign o_pass = r_pass;
    assign o_fail = r_fail;
`endif

    assign o_count     = r_count;
    assign o_signature = w_sig;

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_en) begin
            assert (!$isunknown(i_resp))
                else $error("c6288_response_misr: unknown bits on i_resp while i_resp_valid");
        end
    end
`endif

endmodule
